// File: rtl/core_dmem_pmp_gate.sv
// core_dmem_pmp_gate: buffers one load/store, checks it against the PMP, then forwards it to the
// data bus or answers it with an error; counts trapped requests in a saturating counter.
module core_dmem_pmp_gate #(
    parameter int ADDR_WIDTH = 56,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  cpu_req,
    output logic                  cpu_gnt,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wen,
    input  logic [7:0]            cpu_strb,
    input  logic [63:0]           cpu_wdata,
    input  logic [1:0]            cpu_prv,
    output logic                  cpu_recv,
    input  logic                  cpu_ack,
    output logic [63:0]           cpu_rdata,
    output logic                  cpu_error,
    output logic                  pmp_req,
    output logic [ADDR_WIDTH-1:0] pmp_addr,
    output logic [1:0]            pmp_prv,
    output logic                  pmp_wen,
    input  logic                  pmp_trap,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [7:0]            mem_strb,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_recv,
    output logic                  mem_ack,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_error,
    output logic [CNT_WIDTH-1:0]  trap_count
);
    typedef enum logic [2:0] {IDLE, CHECK, BUS, WAIT, RSP} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic                  buf_wen;
    logic [7:0]            buf_strb;
    logic [63:0]           buf_wdata;
    logic [1:0]            buf_prv;
    logic [63:0]           rsp_rdata;
    logic                  rsp_error;
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= IDLE;
        else           state <= state_nxt;
    end
    // cpu_gnt is qualified by reset so every output reads 0 while reset is held
    always_comb begin
        state_nxt = state;
        cpu_gnt   = g_resetn && (state == IDLE);
        pmp_req   = (state == CHECK);
        mem_req   = (state == BUS);
        mem_ack   = (state == WAIT);
        cpu_recv  = (state == RSP);
        case (state)
            IDLE:    state_nxt = cpu_req  ? CHECK : IDLE;
            CHECK:   state_nxt = pmp_trap ? RSP   : BUS;
            BUS:     state_nxt = mem_gnt  ? WAIT  : BUS;
            WAIT:    state_nxt = mem_recv ? RSP   : WAIT;
            RSP:     state_nxt = cpu_ack  ? IDLE  : RSP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            buf_addr   <= '0;
            buf_wen    <= 1'b0;
            buf_strb   <= '0;
            buf_wdata  <= '0;
            buf_prv    <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            trap_count <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                buf_addr  <= cpu_addr;
                buf_wen   <= cpu_wen;
                buf_strb  <= cpu_strb;
                buf_wdata <= cpu_wdata;
                buf_prv   <= cpu_prv;
            end
            if (state == CHECK && pmp_trap) begin
                rsp_rdata  <= '0;
                rsp_error  <= 1'b1;
                trap_count <= (trap_count == '1) ? trap_count : trap_count + CNT_WIDTH'(1);
            end
            if (state == WAIT && mem_recv) begin
                rsp_rdata <= buf_wen ? '0 : mem_rdata;
                rsp_error <= mem_error;
            end
        end
    end
    assign pmp_addr  = buf_addr;
    assign pmp_prv   = buf_prv;
    assign pmp_wen   = buf_wen;
    assign mem_addr  = buf_addr;
    assign mem_wen   = buf_wen;
    assign mem_strb  = buf_strb;
    assign mem_wdata = buf_wdata;
    assign cpu_rdata = rsp_rdata;
    assign cpu_error = rsp_error;
endmodule

// File: tb/tb_core_dmem_pmp_gate.sv
// tb_core_dmem_pmp_gate: random and directed transactions against a transaction-level model of
// the gate (expected response, latency and trap count derived per request).
module tb_core_dmem_pmp_gate;
    localparam int AW = 56;
    localparam int CW = 8;
    logic          g_clk = 1'b0;
    logic          g_resetn;
    logic          cpu_req = 0, cpu_gnt, cpu_wen = 0, cpu_recv, cpu_ack = 0, cpu_error;
    logic [AW-1:0] cpu_addr = '0, pmp_addr, mem_addr;
    logic [7:0]    cpu_strb = '0, mem_strb;
    logic [63:0]   cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata = '0;
    logic [1:0]    cpu_prv = '0, pmp_prv;
    logic          pmp_req, pmp_wen, pmp_trap = 0;
    logic          mem_req, mem_gnt = 0, mem_wen, mem_recv = 0, mem_ack, mem_error = 0;
    logic [CW-1:0] trap_count;
    int            checks = 0, failures = 0, exp_cnt = 0, cyc = 0;
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc++;
    core_dmem_pmp_gate #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
        .cpu_strb(cpu_strb), .cpu_wdata(cpu_wdata), .cpu_prv(cpu_prv), .cpu_recv(cpu_recv),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_error(cpu_error),
        .pmp_req(pmp_req), .pmp_addr(pmp_addr), .pmp_prv(pmp_prv), .pmp_wen(pmp_wen),
        .pmp_trap(pmp_trap),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .trap_count(trap_count)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction
    // One full transaction; checks are made at negedges, inputs changed after the checks.
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] wd, input logic [1:0] p, input logic trap,
                       input int gd, input int rd, input logic [63:0] rdat, input logic err,
                       input int ad);
        logic [63:0] exp_rd;
        logic        exp_err;
        int          start;
        exp_err = trap | err;
        exp_rd  = (trap | w) ? 64'd0 : rdat;
        chk("gnt_idle", cpu_gnt, 1);
        start = cyc;
        cpu_req = 1; cpu_addr = a; cpu_wen = w; cpu_strb = s; cpu_wdata = wd; cpu_prv = p;
        pmp_trap = trap;
        @(negedge g_clk);
        chk("chk_pmp_req", pmp_req, 1);
        chk("chk_pmp_addr", pmp_addr, a);
        chk("chk_pmp_prv", pmp_prv, p);
        chk("chk_pmp_wen", pmp_wen, w);
        chk("chk_mem_req", mem_req, 0);
        chk("chk_gnt", cpu_gnt, 0);
        cpu_req = 1'($urandom); cpu_addr = AW'(rnd64()); cpu_wen = ~w; cpu_wdata = rnd64();
        cpu_strb = ~s; cpu_prv = ~p;
        @(negedge g_clk);
        pmp_trap = 1'($urandom);
        if (!trap) begin
            for (int i = 0; i <= gd; i++) begin
                chk("bus_req", mem_req, 1);
                chk("bus_addr", mem_addr, a);
                chk("bus_wen", mem_wen, w);
                chk("bus_strb", mem_strb, s);
                chk("bus_wdata", mem_wdata, wd);
                chk("bus_pmp_req", pmp_req, 0);
                chk("bus_ack", mem_ack, 0);
                mem_gnt = (i == gd); mem_recv = (i == gd) && 1'($urandom);
                mem_rdata = ~rdat; mem_error = 1'($urandom);
                @(negedge g_clk);
            end
            mem_gnt = 0;
            for (int i = 0; i <= rd; i++) begin
                chk("wait_ack", mem_ack, 1);
                chk("wait_req", mem_req, 0);
                chk("wait_recv", cpu_recv, 0);
                mem_recv = (i == rd); mem_rdata = (i == rd) ? rdat : rnd64();
                mem_error = (i == rd) ? err : 1'b0;
                @(negedge g_clk);
            end
            mem_recv = 0; mem_error = 0;
        end else begin
            chk("trap_no_mem_req", mem_req, 0);
        end
        chk("latency", 64'(cyc - start), trap ? 64'd2 : 64'(4 + gd + rd));
        for (int i = 0; i <= ad; i++) begin
            chk("rsp_recv", cpu_recv, 1);
            chk("rsp_rdata", cpu_rdata, exp_rd);
            chk("rsp_error", cpu_error, exp_err);
            chk("rsp_gnt", cpu_gnt, 0);
            chk("rsp_mem_req", mem_req, 0);
            cpu_ack = (i == ad); cpu_req = 1'($urandom);
            mem_recv = 1'($urandom);
            @(negedge g_clk);
        end
        cpu_ack = 0; cpu_req = 0; mem_recv = 0;
        if (trap && exp_cnt < 2**CW - 1) exp_cnt++;
        chk("done_recv", cpu_recv, 0);
        chk("done_gnt", cpu_gnt, 1);
        chk("trap_count", trap_count, 64'(exp_cnt));
    endtask
    initial begin
        g_resetn = 1;
        #1 g_resetn = 0;
        #1;
        chk("rst_gnt", cpu_gnt, 0);
        chk("rst_recv", cpu_recv, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pmp_req", pmp_req, 0);
        chk("rst_cnt", trap_count, 0);
        repeat (3) @(negedge g_clk);
        g_resetn = 1;
        @(negedge g_clk);
        txn(AW'(64'h1000), 0, 8'hff, 64'd0, 2'b10, 0, 0, 0, 64'hDEAD, 0, 0);
        txn(AW'(64'h2000), 1, 8'h0f, 64'h1234, 2'b01, 1, 0, 0, 64'd0, 0, 0);
        txn(AW'(64'h3000), 0, 8'hff, 64'd0, 2'b10, 0, 3, 1, 64'hBEEF_CAFE, 0, 0);
        txn(AW'(64'h4000), 0, 8'hff, 64'd0, 2'b01, 0, 0, 0, 64'h5555, 1, 0);
        txn(AW'(64'h5000), 0, 8'hff, 64'd0, 2'b10, 0, 1, 2, 64'h7777, 0, 5);
        txn(AW'(64'h6000), 1, 8'h3c, 64'hAAAA, 2'b10, 0, 0, 0, 64'hFFFF, 0, 0);
        for (int n = 0; n < 150; n++)
            txn(AW'(rnd64()), 1'($urandom), 8'($urandom), rnd64(), ($urandom % 2) ? 2'b10 : 2'b01,
                ($urandom % 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3), rnd64(),
                ($urandom % 4) == 0, $urandom_range(0, 3));
        for (int n = 0; n < 2**CW + 1; n++)
            txn(AW'(rnd64()), 1'($urandom), 8'($urandom), rnd64(), 2'b01, 1, 0, 0, 64'd0, 0, 0);
        chk("cnt_saturated", trap_count, 64'(2**CW - 1));
        cpu_req = 1; cpu_addr = AW'(64'h8000); cpu_wen = 0; pmp_trap = 0;
        @(negedge g_clk);
        cpu_req = 0;
        @(negedge g_clk);
        mem_gnt = 1;
        @(negedge g_clk);
        mem_gnt = 0;
        chk("pre_rst_wait", mem_ack, 1);
        #2 g_resetn = 0; mem_recv = 1; mem_rdata = 64'h99;
        #1;
        chk("arst_gnt", cpu_gnt, 0);
        chk("arst_ack", mem_ack, 0);
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_pmp_req", pmp_req, 0);
        chk("arst_recv", cpu_recv, 0);
        chk("arst_rdata", cpu_rdata, 0);
        chk("arst_error", cpu_error, 0);
        chk("arst_cnt", trap_count, 0);
        @(negedge g_clk);
        g_resetn = 1; mem_recv = 0;
        exp_cnt = 0;
        @(negedge g_clk);
        chk("post_rst_gnt", cpu_gnt, 1);
        chk("post_rst_recv", cpu_recv, 0);
        txn(AW'(64'h9000), 0, 8'hff, 64'd0, 2'b10, 0, 0, 0, 64'h4242, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
